// File: rtl/gol_pkg.sv
// Shared game-of-life definitions: board size, ASCII codes and the frame-dumper state encoding.
package gol_pkg;

  localparam int GOL_WIDTH  = 16;
  localparam int GOL_HEIGHT = 16;

  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_DOT  = 8'h2E;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_CELL,
    S_EOL,
    S_SEP
  } dump_state_e;

endpackage

// File: rtl/gol_frame_dumper.sv
// Reads the cell grid row by row and streams it as ASCII ('#'/'.' per cell, LF per row,
// extra LF per frame) over a registered valid/ready byte interface.
module gol_frame_dumper
  import gol_pkg::*;
#(
  parameter int         WIDTH    = GOL_WIDTH,
  parameter int         HEIGHT   = GOL_HEIGHT,
  parameter logic [7:0] CH_ALIVE = ASCII_HASH,
  parameter logic [7:0] CH_DEAD  = ASCII_DOT,
  parameter int         ROW_AW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ROW_AW-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(HEIGHT - 1);

  dump_state_e       state_q, state_d;
  logic [ROW_AW-1:0] row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [WIDTH-1:0]  row_word_q, row_word_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              done_q, done_d;
  logic              hs;

  assign hs = tx_valid_q && tx_ready;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    row_word_d = row_word_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The cycle carrying done is still IDLE; a start there is deliberately dropped.
        if (start && !done_q) begin
          state_d = S_FETCH;
          row_d   = '0;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        row_word_d = rd_data;
        col_d      = '0;
        state_d    = S_CELL;
      end
      S_CELL: begin
        if (hs) begin
          if (col_q == COL_LAST) state_d = S_EOL;
          else                   col_d   = col_q + COL_W'(1);
        end
      end
      S_EOL: begin
        if (hs) begin
          if (row_q == ROW_LAST) begin
            state_d = S_SEP;
          end else begin
            row_d   = row_q + ROW_AW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_SEP: begin
        if (hs) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The byte register is loaded from next-state values, so it changes only on a
    // handshake or a state step and holds steady through any stall.
    tx_valid_d = (state_d == S_CELL) || (state_d == S_EOL) || (state_d == S_SEP);
    tx_data_d  = 8'h00;
    unique case (state_d)
      S_CELL:       tx_data_d = row_word_d[col_d] ? CH_ALIVE : CH_DEAD;
      S_EOL, S_SEP: tx_data_d = ASCII_LF;
      default:      tx_data_d = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      row_word_q <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      row_word_q <= row_word_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign rd_en    = (state_q == S_FETCH);
  assign rd_addr  = row_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_gol_frame_dumper.sv
// Directed bench for gol_frame_dumper on a 4x3 board with a 1-cycle-latency grid model.
module tb_gol_frame_dumper;

  localparam int W = 4;
  localparam int H = 3;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, rd_en, tx_valid, tx_ready;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data = '0;
  logic [7:0]    tx_data;

  logic          ready_fixed = 1'b1;
  logic          rand_mode = 1'b0;
  logic          rnd_q = 1'b0;
  logic [W-1:0]  rows [H];

  int errors = 0;
  int checks = 0;

  // Monitor state, written only by the posedge monitor below.
  byte unsigned got[$];
  int           addr_log[$];
  int           done_cnt = 0;
  int           rd_cnt = 0;
  int           stall_err = 0;
  logic         stall_pending = 1'b0;
  logic [7:0]   stall_data = 8'h00;

  gol_frame_dumper #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  assign tx_ready = rand_mode ? rnd_q : ready_fixed;

  always @(negedge clk) rnd_q = 1'($urandom_range(0, 1));

  always @(posedge clk) begin
    if (rd_en) rd_data <= rows[rd_addr];
  end

  always @(posedge clk) begin
    if (tx_valid && tx_ready) got.push_back(tx_data);
    if (done) done_cnt++;
    if (rd_en) begin
      rd_cnt++;
      addr_log.push_back(int'(rd_addr));
    end
    if (stall_pending && !rst && !(tx_valid && tx_data == stall_data)) stall_err++;
    stall_pending = !rst && tx_valid && !tx_ready;
    stall_data    = tx_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed=\"%s\" expected=\"%s\"", tag, obs, exp);
    end
  endtask

  // Bytes captured since index 'from', LF shown as '|' to keep report lines single.
  function automatic string stream_from(input int from);
    string s = "";
    for (int i = from; i < got.size(); i++) begin
      if (got[i] == 8'h0A) s = {s, "|"};
      else                 s = {s, string'(got[i])};
    end
    return s;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 1000), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base, d0, r0, a0, bad, n;

    rows[0] = 4'b0001;
    rows[1] = 4'b1010;
    rows[2] = 4'b1111;

    // 1: reset and idle
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid || rd_en || busy) bad++;
      @(negedge clk);
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // 2: free-running sink
    base = got.size(); d0 = done_cnt; r0 = rd_cnt;
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done("t2", d0);
    check("t2_busy_in_done", 32'(busy), 32'd0);
    idle(5);
    check_str("t2_stream", stream_from(base), "#...|.#.#|####||");
    check("t2_len", 32'(got.size() - base), 32'd16);
    check("t2_done_once", 32'(done_cnt - d0), 32'd1);
    check("t2_rd_cnt", 32'(rd_cnt - r0), 32'd3);

    // 3: random backpressure
    base = got.size(); d0 = done_cnt;
    rand_mode = 1'b1;
    pulse_start();
    wait_done("t3", d0);
    rand_mode = 1'b0;
    idle(5);
    check_str("t3_stream", stream_from(base), "#...|.#.#|####||");
    check("t3_stall_stable", 32'(stall_err), 32'd0);
    check("t3_done_once", 32'(done_cnt - d0), 32'd1);

    // 4: second start mid-frame is ignored
    base = got.size(); d0 = done_cnt; r0 = rd_cnt;
    pulse_start();
    idle(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4", d0);
    idle(30);
    check_str("t4_stream", stream_from(base), "#...|.#.#|####||");
    check("t4_done_once", 32'(done_cnt - d0), 32'd1);
    check("t4_rd_cnt", 32'(rd_cnt - r0), 32'd3);
    check("t4_idle_after", 32'(busy), 32'd0);

    // 5: reset after the 6th accepted byte aborts the frame
    base = got.size(); d0 = done_cnt;
    pulse_start();
    n = 0;
    while (got.size() - base < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach6_timeout", 32'(n < 200), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(10);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_stays_idle", 32'(tx_valid), 32'd0);
    base = got.size(); d0 = done_cnt;
    pulse_start();
    wait_done("t5", d0);
    idle(3);
    check_str("t5_stream", stream_from(base), "#...|.#.#|####||");

    // 6: all-zero then all-ones boards, row addresses in order
    rows[0] = 4'b0000; rows[1] = 4'b0000; rows[2] = 4'b0000;
    base = got.size(); d0 = done_cnt; a0 = addr_log.size();
    pulse_start();
    wait_done("t6z", d0);
    idle(3);
    check_str("t6_zero_stream", stream_from(base), "....|....|....||");
    check("t6_addr_cnt", 32'(addr_log.size() - a0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (a0 + i < addr_log.size())
        check($sformatf("t6_addr%0d", i), 32'(addr_log[a0 + i]), 32'(i));
    end
    rows[0] = 4'b1111; rows[1] = 4'b1111; rows[2] = 4'b1111;
    base = got.size(); d0 = done_cnt;
    pulse_start();
    wait_done("t6o", d0);
    idle(3);
    check_str("t6_ones_stream", stream_from(base), "####|####|####||");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
